// File: rtl/mac_pack.sv
// GMII transmit framer: preamble/SFD, MAC header, payload, zero pad, CRC-32 FCS, IFG.
// One-cycle registered output latency; no backpressure, payload pulled via pkt_rd, pkt_start ignored while busy.
module mac_pack #(
  parameter logic [47:0] LOCAL_MAC   = 48'h00_0A_35_01_02_03,
  parameter int          IFG_BYTES   = 12,
  parameter int          MIN_PAYLOAD = 46
) (
  input  logic        rx_clk,
  input  logic        rst_n,
  input  logic        pkt_start,
  input  logic [10:0] pkt_len,
  input  logic [47:0] des_mac,
  input  logic [15:0] prot_type,
  input  logic [7:0]  pkt_dat,
  output logic        pkt_rd,
  output logic        busy,
  output logic        tx_en,
  output logic        tx_er,
  output logic [7:0]  txd
);

  typedef enum logic [3:0] {
    S_IDLE, S_PREAMBLE, S_SFD, S_DES_MAC, S_SRC_MAC,
    S_PROT_TYPE, S_PAYLOAD, S_PAD, S_FCS, S_IFG
  } state_t;

  localparam logic [10:0] W_MIN    = 11'(MIN_PAYLOAD);
  localparam logic [10:0] W_IFG_M1 = 11'(IFG_BYTES - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [10:0] r_byte_cnt;
  logic [10:0] r_len;
  logic [47:0] r_des_mac;
  logic [15:0] r_prot;
  logic [31:0] r_crc;
  logic [31:0] w_fcs;
  logic [7:0]  w_byte;
  logic        w_tx_en;
  logic        w_crc_en;

  function automatic logic [7:0] mac_byte(input logic [47:0] m, input logic [2:0] i);
    case (i)
      3'd0:    return m[47:40];
      3'd1:    return m[39:32];
      3'd2:    return m[31:24];
      3'd3:    return m[23:16];
      3'd4:    return m[15:8];
      default: return m[7:0];
    endcase
  endfunction

  // Reflected CRC-32, data consumed LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    end
    return r;
  endfunction

  assign w_fcs = ~r_crc;

  always_comb begin
    w_state_nxt = r_state;
    w_byte      = 8'h00;
    w_tx_en     = 1'b0;
    w_crc_en    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (pkt_start) w_state_nxt = S_PREAMBLE;
      end
      S_PREAMBLE: begin
        w_byte  = 8'h55;
        w_tx_en = 1'b1;
        if (r_byte_cnt == 11'd6) w_state_nxt = S_SFD;
      end
      S_SFD: begin
        w_byte      = 8'hD5;
        w_tx_en     = 1'b1;
        w_state_nxt = S_DES_MAC;
      end
      S_DES_MAC: begin
        w_byte   = mac_byte(r_des_mac, r_byte_cnt[2:0]);
        w_tx_en  = 1'b1;
        w_crc_en = 1'b1;
        if (r_byte_cnt == 11'd5) w_state_nxt = S_SRC_MAC;
      end
      S_SRC_MAC: begin
        w_byte   = mac_byte(LOCAL_MAC, r_byte_cnt[2:0]);
        w_tx_en  = 1'b1;
        w_crc_en = 1'b1;
        if (r_byte_cnt == 11'd5) w_state_nxt = S_PROT_TYPE;
      end
      S_PROT_TYPE: begin
        w_byte   = r_byte_cnt[0] ? r_prot[7:0] : r_prot[15:8];
        w_tx_en  = 1'b1;
        w_crc_en = 1'b1;
        if (r_byte_cnt == 11'd1) w_state_nxt = (r_len != 11'd0) ? S_PAYLOAD : S_PAD;
      end
      S_PAYLOAD: begin
        w_byte   = pkt_dat;
        w_tx_en  = 1'b1;
        w_crc_en = 1'b1;
        if (r_byte_cnt == r_len - 11'd1) w_state_nxt = (r_len < W_MIN) ? S_PAD : S_FCS;
      end
      S_PAD: begin
        w_tx_en  = 1'b1;
        w_crc_en = 1'b1;
        if (r_byte_cnt == W_MIN - r_len - 11'd1) w_state_nxt = S_FCS;
      end
      S_FCS: begin
        w_tx_en = 1'b1;
        case (r_byte_cnt[1:0])
          2'd0:    w_byte = w_fcs[7:0];
          2'd1:    w_byte = w_fcs[15:8];
          2'd2:    w_byte = w_fcs[23:16];
          default: w_byte = w_fcs[31:24];
        endcase
        if (r_byte_cnt == 11'd3) w_state_nxt = S_IFG;
      end
      S_IFG: begin
        if (r_byte_cnt == W_IFG_M1) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_byte_cnt <= 11'd0;
      r_len      <= 11'd0;
      r_des_mac  <= 48'd0;
      r_prot     <= 16'd0;
      r_crc      <= 32'hFFFF_FFFF;
      tx_en      <= 1'b0;
      txd        <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE || w_state_nxt != r_state) r_byte_cnt <= 11'd0;
      else                                             r_byte_cnt <= r_byte_cnt + 11'd1;
      if (r_state == S_IDLE && pkt_start) begin
        r_len     <= pkt_len;
        r_des_mac <= des_mac;
        r_prot    <= prot_type;
      end
      if (r_state == S_SFD) r_crc <= 32'hFFFF_FFFF;
      else if (w_crc_en)    r_crc <= crc_byte(r_crc, w_byte);
      tx_en <= w_tx_en;
      txd   <= w_byte;
    end
  end

  assign pkt_rd = (r_state == S_PAYLOAD);
  assign busy   = (r_state != S_IDLE);
  assign tx_er  = 1'b0;

endmodule
